// File: rtl/mips_mem_lsu_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_lsu_pkg
// Shared MIPS memory-stage definitions.
// Contents:
//   - Datapath widths (data, byte address, register-file index).
//   - 2-bit LSU FSM encodings and the enum type built on them.
//   - Helper that flags a word access whose byte offset is non-zero.
// ---------------------------------------------------------------------------
package mips_mem_lsu_pkg;

    localparam int MIPS_DATA_WIDTH  = 32;
    localparam int MIPS_ADDR_WIDTH  = 32;
    localparam int MIPS_RFIDX_WIDTH = 5;

    localparam logic [1:0] MIPS_LSU_IDLE     = 2'd0;
    localparam logic [1:0] MIPS_LSU_REQ      = 2'd1;
    localparam logic [1:0] MIPS_LSU_WAIT_RSP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE     = MIPS_LSU_IDLE,
        ST_REQ      = MIPS_LSU_REQ,
        ST_WAIT_RSP = MIPS_LSU_WAIT_RSP
    } lsu_state_e;

    // Only whole-word accesses are supported, so any set low address bit
    // means the access cannot be issued to memory.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |byte_off;
    endfunction

endpackage

// File: rtl/mips_mem_req_buf.sv
// ---------------------------------------------------------------------------
// mips_mem_req_buf
// Holding register for the instruction accepted from EX. The payload is
// captured when cap_en is high and held until the next capture or reset.
// Ports:
//   clk, rst           clock, synchronous active-high reset (clears payload)
//   cap_en             capture strobe (EX handshake)
//   in_*               payload presented by EX / the LSU
//   hold_*             registered payload
// ---------------------------------------------------------------------------
module mips_mem_req_buf
    import mips_mem_lsu_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cap_en,
    input  logic                        in_is_load,
    input  logic                        in_we,
    input  logic [MIPS_ADDR_WIDTH-1:0]  in_addr,
    input  logic [MIPS_DATA_WIDTH-1:0]  in_wdat,
    input  logic [MIPS_RFIDX_WIDTH-1:0] in_rd_idx,
    input  logic [MIPS_DATA_WIDTH-1:0]  in_rd_wdat,
    input  logic                        in_rd_wen,
    output logic                        hold_is_load,
    output logic                        hold_we,
    output logic [MIPS_ADDR_WIDTH-1:0]  hold_addr,
    output logic [MIPS_DATA_WIDTH-1:0]  hold_wdat,
    output logic [MIPS_RFIDX_WIDTH-1:0] hold_rd_idx,
    output logic [MIPS_DATA_WIDTH-1:0]  hold_rd_wdat,
    output logic                        hold_rd_wen
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_is_load <= 1'b0;
            hold_we      <= 1'b0;
            hold_addr    <= '0;
            hold_wdat    <= '0;
            hold_rd_idx  <= '0;
            hold_rd_wdat <= '0;
            hold_rd_wen  <= 1'b0;
        end else if (cap_en) begin
            hold_is_load <= in_is_load;
            hold_we      <= in_we;
            hold_addr    <= in_addr;
            hold_wdat    <= in_wdat;
            hold_rd_idx  <= in_rd_idx;
            hold_rd_wdat <= in_rd_wdat;
            hold_rd_wen  <= in_rd_wen;
        end
    end

endmodule

// File: rtl/mips_mem_lsu.sv
// ---------------------------------------------------------------------------
// mips_mem_lsu
// MIPS memory-stage load/store unit. Accepts one instruction at a time from
// EX, issues at most one data-memory request, and emits a one-cycle mem2wb
// pulse per accepted instruction.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex2mem_*                    instruction from EX (valid/ready handshake)
//   dmem_req_*                  data-memory request (valid/ready handshake)
//   dmem_rsp_valid/rdat         load response, only honoured in WAIT_RSP
//   mem2wb_*                    registered writeback result
// ---------------------------------------------------------------------------
module mips_mem_lsu
    import mips_mem_lsu_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ex2mem_valid,
    output logic                        ex2mem_ready,
    input  logic                        ex2mem_mem_read,
    input  logic                        ex2mem_mem_write,
    input  logic [MIPS_ADDR_WIDTH-1:0]  ex2mem_mem_addr,
    input  logic [MIPS_DATA_WIDTH-1:0]  ex2mem_mem_wdat,
    input  logic [MIPS_RFIDX_WIDTH-1:0] ex2mem_rd_idx,
    input  logic [MIPS_DATA_WIDTH-1:0]  ex2mem_rd_wdat,
    input  logic                        ex2mem_rd_wen,
    output logic                        dmem_req_valid,
    input  logic                        dmem_req_ready,
    output logic                        dmem_req_we,
    output logic [MIPS_ADDR_WIDTH-1:0]  dmem_req_addr,
    output logic [MIPS_DATA_WIDTH-1:0]  dmem_req_wdat,
    input  logic                        dmem_rsp_valid,
    input  logic [MIPS_DATA_WIDTH-1:0]  dmem_rsp_rdat,
    output logic                        mem2wb_valid,
    output logic                        mem2wb_rd_wen,
    output logic                        mem2wb_misalign,
    output logic [MIPS_RFIDX_WIDTH-1:0] mem2wb_rd_idx,
    output logic [MIPS_DATA_WIDTH-1:0]  mem2wb_rd_wdat
);

    lsu_state_e                  state_reg;
    logic                        wb_valid_reg;
    logic                        wb_rd_wen_reg;
    logic                        wb_misalign_reg;
    logic [MIPS_RFIDX_WIDTH-1:0] wb_rd_idx_reg;
    logic [MIPS_DATA_WIDTH-1:0]  wb_rd_wdat_reg;

    logic                        accept;
    logic                        mem_op;
    logic                        misalign;

    logic                        hold_is_load;
    logic                        hold_we;
    logic [MIPS_ADDR_WIDTH-1:0]  hold_addr;
    logic [MIPS_DATA_WIDTH-1:0]  hold_wdat;
    logic [MIPS_RFIDX_WIDTH-1:0] hold_rd_idx;
    logic [MIPS_DATA_WIDTH-1:0]  hold_rd_wdat;
    logic                        hold_rd_wen;

    assign ex2mem_ready = (state_reg == ST_IDLE);
    assign accept       = ex2mem_valid & ex2mem_ready;
    assign mem_op       = ex2mem_mem_read | ex2mem_mem_write;
    assign misalign     = mem_op & is_misaligned(ex2mem_mem_addr[1:0]);

    // A load wins over a simultaneous store request, so the write enable is
    // only set for a pure store.
    mips_mem_req_buf u_req_buf (
        .clk          (clk),
        .rst          (rst),
        .cap_en       (accept),
        .in_is_load   (ex2mem_mem_read),
        .in_we        (ex2mem_mem_write & ~ex2mem_mem_read),
        .in_addr      (ex2mem_mem_addr),
        .in_wdat      (ex2mem_mem_wdat),
        .in_rd_idx    (ex2mem_rd_idx),
        .in_rd_wdat   (ex2mem_rd_wdat),
        .in_rd_wen    (ex2mem_rd_wen),
        .hold_is_load (hold_is_load),
        .hold_we      (hold_we),
        .hold_addr    (hold_addr),
        .hold_wdat    (hold_wdat),
        .hold_rd_idx  (hold_rd_idx),
        .hold_rd_wdat (hold_rd_wdat),
        .hold_rd_wen  (hold_rd_wen)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            wb_valid_reg    <= 1'b0;
            wb_rd_wen_reg   <= 1'b0;
            wb_misalign_reg <= 1'b0;
            wb_rd_idx_reg   <= '0;
            wb_rd_wdat_reg  <= '0;
        end else begin
            // Pulse by default; payload registers keep their last values.
            wb_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (mem_op && !misalign) begin
                            state_reg <= ST_REQ;
                        end else begin
                            // Non-memory op or misaligned access: retire
                            // immediately straight from the EX payload.
                            wb_valid_reg    <= 1'b1;
                            wb_rd_idx_reg   <= ex2mem_rd_idx;
                            wb_rd_wdat_reg  <= ex2mem_rd_wdat;
                            wb_rd_wen_reg   <= mem_op ? 1'b0 : ex2mem_rd_wen;
                            wb_misalign_reg <= mem_op;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        if (hold_is_load) begin
                            state_reg <= ST_WAIT_RSP;
                        end else begin
                            state_reg       <= ST_IDLE;
                            wb_valid_reg    <= 1'b1;
                            wb_rd_idx_reg   <= hold_rd_idx;
                            wb_rd_wdat_reg  <= hold_rd_wdat;
                            wb_rd_wen_reg   <= 1'b0;
                            wb_misalign_reg <= 1'b0;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (dmem_rsp_valid) begin
                        state_reg       <= ST_IDLE;
                        wb_valid_reg    <= 1'b1;
                        wb_rd_idx_reg   <= hold_rd_idx;
                        wb_rd_wdat_reg  <= dmem_rsp_rdat;
                        wb_rd_wen_reg   <= hold_rd_wen;
                        wb_misalign_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Request payload comes only from the holding register, so it cannot
    // move while the memory stalls the handshake.
    assign dmem_req_valid  = (state_reg == ST_REQ);
    assign dmem_req_we     = hold_we;
    assign dmem_req_addr   = hold_addr;
    assign dmem_req_wdat   = hold_wdat;

    assign mem2wb_valid    = wb_valid_reg;
    assign mem2wb_rd_wen   = wb_rd_wen_reg;
    assign mem2wb_misalign = wb_misalign_reg;
    assign mem2wb_rd_idx   = wb_rd_idx_reg;
    assign mem2wb_rd_wdat  = wb_rd_wdat_reg;

endmodule

// File: tb/tb_mips_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mips_mem_lsu
// Directed bench for mips_mem_lsu. Each stimulus task derives, from the
// transaction alone, the cycle and payload of the expected mem2wb pulse and
// the request the memory should see; a per-cycle compare process checks the
// DUT against those expectations. A few literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_mips_mem_lsu;

    logic        clk;
    logic        rst;
    logic        ex2mem_valid;
    logic        ex2mem_ready;
    logic        ex2mem_mem_read;
    logic        ex2mem_mem_write;
    logic [31:0] ex2mem_mem_addr;
    logic [31:0] ex2mem_mem_wdat;
    logic [4:0]  ex2mem_rd_idx;
    logic [31:0] ex2mem_rd_wdat;
    logic        ex2mem_rd_wen;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdat;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdat;
    logic        mem2wb_valid;
    logic        mem2wb_rd_wen;
    logic        mem2wb_misalign;
    logic [4:0]  mem2wb_rd_idx;
    logic [31:0] mem2wb_rd_wdat;

    mips_mem_lsu dut (
        .clk              (clk),
        .rst              (rst),
        .ex2mem_valid     (ex2mem_valid),
        .ex2mem_ready     (ex2mem_ready),
        .ex2mem_mem_read  (ex2mem_mem_read),
        .ex2mem_mem_write (ex2mem_mem_write),
        .ex2mem_mem_addr  (ex2mem_mem_addr),
        .ex2mem_mem_wdat  (ex2mem_mem_wdat),
        .ex2mem_rd_idx    (ex2mem_rd_idx),
        .ex2mem_rd_wdat   (ex2mem_rd_wdat),
        .ex2mem_rd_wen    (ex2mem_rd_wen),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req_we      (dmem_req_we),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_wdat    (dmem_req_wdat),
        .dmem_rsp_valid   (dmem_rsp_valid),
        .dmem_rsp_rdat    (dmem_rsp_rdat),
        .mem2wb_valid     (mem2wb_valid),
        .mem2wb_rd_wen    (mem2wb_rd_wen),
        .mem2wb_misalign  (mem2wb_misalign),
        .mem2wb_rd_idx    (mem2wb_rd_idx),
        .mem2wb_rd_wdat   (mem2wb_rd_wdat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int          at;
        logic [4:0]  idx;
        logic [31:0] wdat;
        logic        wen;
        logic        mis;
    } wb_t;

    wb_t         exp_q[$];
    logic        exp_ready     = 1'b1;
    logic        exp_req_valid = 1'b0;
    logic        exp_req_we    = 1'b0;
    logic [31:0] exp_req_addr  = '0;
    logic [31:0] exp_req_wdat  = '0;

    task automatic push_wb(input int at, input logic [4:0] idx, input logic [31:0] wdat,
                           input logic wen, input logic mis);
        wb_t e;
        e.at = at; e.idx = idx; e.wdat = wdat; e.wen = wen; e.mis = mis;
        exp_q.push_back(e);
    endtask

    // Per-cycle compare against the model.
    initial begin : compare
        logic        rst_at_edge;
        logic [4:0]  last_idx;
        logic [31:0] last_wdat;
        logic        last_wen;
        logic        last_mis;
        logic        want_pulse;
        last_idx = '0; last_wdat = '0; last_wen = 1'b0; last_mis = 1'b0;
        forever begin
            @(posedge clk);
            rst_at_edge = rst;
            @(negedge clk);
            if (rst_at_edge) begin
                last_idx = '0; last_wdat = '0; last_wen = 1'b0; last_mis = 1'b0;
            end
            want_pulse = (exp_q.size() > 0) && (exp_q[0].at == cyc);
            if (want_pulse) begin
                last_idx  = exp_q[0].idx;
                last_wdat = exp_q[0].wdat;
                last_wen  = exp_q[0].wen;
                last_mis  = exp_q[0].mis;
                void'(exp_q.pop_front());
            end
            chk("mem2wb_valid", {31'd0, mem2wb_valid}, {31'd0, want_pulse});
            chk("mem2wb_rd_idx", {27'd0, mem2wb_rd_idx}, {27'd0, last_idx});
            chk("mem2wb_rd_wdat", mem2wb_rd_wdat, last_wdat);
            chk("mem2wb_rd_wen", {31'd0, mem2wb_rd_wen}, {31'd0, last_wen});
            chk("mem2wb_misalign", {31'd0, mem2wb_misalign}, {31'd0, last_mis});
            chk("ex2mem_ready", {31'd0, ex2mem_ready}, {31'd0, exp_ready});
            chk("dmem_req_valid", {31'd0, dmem_req_valid}, {31'd0, exp_req_valid});
            if (exp_req_valid) begin
                chk("dmem_req_we", {31'd0, dmem_req_we}, {31'd0, exp_req_we});
                chk("dmem_req_addr", dmem_req_addr, exp_req_addr);
                chk("dmem_req_wdat", dmem_req_wdat, exp_req_wdat);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Starts in the current cycle (inputs driven just after a rising edge)
    // and returns in the cycle the LSU is back in IDLE.
    task automatic op(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdat, input logic [4:0] idx,
                      input logic [31:0] rdw, input logic wen,
                      input int req_wait, input int rsp_dly,
                      input logic [31:0] rsp_dat, input logic spur,
                      input logic rst_mid);
        int   a;
        int   h;
        logic is_mem;
        logic is_mis;
        a      = cyc;
        is_mem = rd | wr;
        is_mis = is_mem && (addr[1:0] != 2'b00);
        ex2mem_valid     = 1'b1;
        ex2mem_mem_read  = rd;
        ex2mem_mem_write = wr;
        ex2mem_mem_addr  = addr;
        ex2mem_mem_wdat  = wdat;
        ex2mem_rd_idx    = idx;
        ex2mem_rd_wdat   = rdw;
        ex2mem_rd_wen    = wen;
        exp_ready        = 1'b1;
        if (!is_mem || is_mis) begin
            push_wb(a + 1, idx, rdw, is_mis ? 1'b0 : wen, is_mis);
            @(posedge clk); #1;
            ex2mem_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        ex2mem_valid  = 1'b0;
        exp_ready     = 1'b0;
        exp_req_valid = 1'b1;
        exp_req_we    = wr & ~rd;
        exp_req_addr  = addr;
        exp_req_wdat  = wdat;
        for (int k = 0; k <= req_wait; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            dmem_req_ready = (k == req_wait);
            dmem_rsp_valid = spur;
            dmem_rsp_rdat  = 32'h5A5A_5A5A;
        end
        h = cyc;
        @(posedge clk); #1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        exp_req_valid  = 1'b0;
        if (!rd) begin
            push_wb(h + 1, idx, rdw, 1'b0, 1'b0);
            exp_ready = 1'b1;
            return;
        end
        if (rst_mid) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst            = 1'b0;
            exp_ready      = 1'b1;
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdat  = rsp_dat;
            @(posedge clk); #1;
            dmem_rsp_valid = 1'b0;
            return;
        end
        for (int k = 1; k < rsp_dly; k++) begin
            @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdat  = rsp_dat;
        push_wb(cyc + 1, idx, rsp_dat, wen, 1'b0);
        @(posedge clk); #1;
        dmem_rsp_valid = 1'b0;
        exp_ready      = 1'b1;
    endtask

    task automatic idle(input int n, input logic spur);
        for (int k = 0; k < n; k++) begin
            dmem_rsp_valid = spur;
            dmem_rsp_rdat  = 32'hBAD0_BAD0;
            @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : main
        rst = 1'b1;
        ex2mem_valid = 1'b0; ex2mem_mem_read = 1'b0; ex2mem_mem_write = 1'b0;
        ex2mem_mem_addr = '0; ex2mem_mem_wdat = '0; ex2mem_rd_idx = '0;
        ex2mem_rd_wdat = '0; ex2mem_rd_wen = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdat = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2, 1'b0);

        // Three back-to-back non-memory ops.
        for (int i = 0; i < 3; i++)
            op(1'b0, 1'b0, 32'h0, 32'h0, 5'd5, 32'h1234, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_nonmem_idx", {27'd0, mem2wb_rd_idx}, 32'd5);
        chk("pin_nonmem_wdat", mem2wb_rd_wdat, 32'h1234);
        @(posedge clk); #1;

        // Store with memory stalling three cycles.
        op(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 5'd7, 32'h77, 1'b1, 3, 0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_store_pulse", {31'd0, mem2wb_valid}, 32'd1);
        chk("pin_store_wen", {31'd0, mem2wb_rd_wen}, 32'd0);
        @(posedge clk); #1;

        // Load with response four cycles after the handshake.
        op(1'b1, 1'b0, 32'h200, 32'h0, 5'd9, 32'h0, 1'b1, 0, 4, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_load_rdat", mem2wb_rd_wdat, 32'hCAFE_F00D);
        chk("pin_load_idx", {27'd0, mem2wb_rd_idx}, 32'd9);
        @(posedge clk); #1;

        // Spurious responses while idle.
        idle(2, 1'b1);

        // Misaligned load.
        op(1'b1, 1'b0, 32'h203, 32'h0, 5'd3, 32'h33, 1'b1, 0, 1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pin_misalign", {31'd0, mem2wb_misalign}, 32'd1);
        chk("pin_misalign_wen", {31'd0, mem2wb_rd_wen}, 32'd0);
        @(posedge clk); #1;

        // Read+write together is a load; spurious responses during REQ.
        op(1'b1, 1'b1, 32'h300, 32'h1111_1111, 5'd4, 32'h0, 1'b1, 2, 1, 32'h0000_00A5, 1'b1, 1'b0);
        // Misaligned store, then a non-memory op straight into a load.
        op(1'b0, 1'b1, 32'h102, 32'h2222_2222, 5'd6, 32'h66, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
        op(1'b0, 1'b0, 32'h0, 32'h0, 5'd12, 32'h0ABC, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0);
        op(1'b1, 1'b0, 32'h404, 32'h0, 5'd31, 32'h0, 1'b1, 1, 2, 32'h1357_9BDF, 1'b0, 1'b0);
        // Store whose memory accepts immediately.
        op(1'b0, 1'b1, 32'h408, 32'h0F0F_0F0F, 5'd2, 32'h22, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
        idle(1, 1'b0);

        // Reset while waiting for a load response.
        op(1'b1, 1'b0, 32'h500, 32'h0, 5'd8, 32'h0, 1'b1, 0, 1, 32'hFFFF_0000, 1'b0, 1'b1);
        idle(3, 1'b1);
        op(1'b0, 1'b0, 32'h0, 32'h0, 5'd1, 32'h0000_0042, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0);
        idle(3, 1'b0);

        @(negedge clk);
        chk("expect_queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
